// File: rtl/countdown_timer.sv
// Minute/second countdown timer with a 1 Hz prescaler and packed-BCD outputs.
// Drives the buzzer/alarm stage and the 7-segment display path directly.
module countdown_timer #(
  parameter int CLK_DIV = 50_000_000,
  parameter int PW      = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] set_fen,
  input  logic [7:0] set_miao,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] fen,
  output logic [7:0] miao,
  output logic       running,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic          time_nz;
  logic          wrap;

  // Saturate each BCD digit so a bad preset can never produce an illegal value.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [3:0] tens_max);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > tens_max) ? tens_max : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  function automatic logic [7:0] dec_bcd(input logic [7:0] v);
    return (v[3:0] != 4'd0) ? {v[7:4], v[3:0] - 4'd1} : {v[7:4] - 4'd1, 4'd9};
  endfunction

  assign time_nz = (fen != 8'h00) || (miao != 8'h00);
  assign wrap    = (presc == PW'(CLK_DIV - 1));
  assign running = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      fen   <= 8'h00;
      miao  <= 8'h00;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state <= IDLE;
        presc <= '0;
        fen   <= 8'h00;
        miao  <= 8'h00;
      end else if (load && state != RUN) begin
        state <= IDLE;
        fen   <= clamp_bcd(set_fen, 4'd9);
        miao  <= clamp_bcd(set_miao, 4'd5);
      end else if (start && (state == IDLE || state == PAUSE) && time_nz) begin
        state <= RUN;
        // Resuming from PAUSE keeps the partial second already counted.
        if (state == IDLE) presc <= '0;
      end else if (pause && state == RUN) begin
        state <= PAUSE;
      end else if (state == RUN) begin
        if (wrap) begin
          presc <= '0;
          if (miao != 8'h00) begin
            miao <= dec_bcd(miao);
            if (fen == 8'h00 && miao == 8'h01) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            miao <= 8'h59;
            fen  <= dec_bcd(fen);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, async reset
// sequence, and randomized commands against a seconds-based reference model.
module tb_countdown_timer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, start, pause, clear;
  logic [7:0] set_fen, set_miao;
  logic [7:0] fen, miao;
  logic       running, done;

  always #5 clk = ~clk;

  countdown_timer #(.CLK_DIV(CLK_DIV), .PW(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .set_fen(set_fen), .set_miao(set_miao),
    .start(start), .pause(pause), .clear(clear),
    .fen(fen), .miao(miao), .running(running), .done(done)
  );

  typedef struct {
    logic       clr, ld, st, ps;
    logic [7:0] sf, sm;
    int         n;
    logic [7:0] ef, em;
    logic       er, ed;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic chk_all(input string nm, input logic [7:0] ef, input logic [7:0] em,
                         input logic er, input logic ed);
    chk({nm, ".fen"}, fen, ef);
    chk({nm, ".miao"}, miao, em);
    chk({nm, ".running"}, {7'd0, running}, {7'd0, er});
    chk({nm, ".done"}, {7'd0, done}, {7'd0, ed});
  endtask

  task automatic add(input string nm, input logic clr, input logic ld, input logic st,
                     input logic ps, input logic [7:0] sf, input logic [7:0] sm, input int n,
                     input logic [7:0] ef, input logic [7:0] em, input logic er, input logic ed);
    vec_t v;
    v.nm = nm; v.clr = clr; v.ld = ld; v.st = st; v.ps = ps; v.sf = sf; v.sm = sm;
    v.n = n; v.ef = ef; v.em = em; v.er = er; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic ld, input logic st, input logic ps,
                       input logic [7:0] sf, input logic [7:0] sm);
    clear = clr; load = ld; start = st; pause = ps; set_fen = sf; set_miao = sm;
  endtask

  // Reference model: time kept as plain seconds, prescaler as a cycle count.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  mst_t m_st;
  int   m_secs, m_pre;
  logic m_done;

  function automatic int clamp_val(input logic [7:0] v, input int tmax);
    int t, u;
    t = int'(v[7:4]); u = int'(v[3:0]);
    if (t > tmax) t = tmax;
    if (u > 9) u = 9;
    return t * 10 + u;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (clear) begin
      m_secs = 0; m_pre = 0; m_st = M_IDLE;
    end else if (load && m_st != M_RUN) begin
      m_secs = clamp_val(set_fen, 9) * 60 + clamp_val(set_miao, 5);
      m_st = M_IDLE;
    end else if (start && (m_st == M_IDLE || m_st == M_PAUSE) && m_secs > 0) begin
      if (m_st == M_IDLE) m_pre = 0;
      m_st = M_RUN;
    end else if (pause && m_st == M_RUN) begin
      m_st = M_PAUSE;
    end else if (m_st == M_RUN) begin
      m_pre++;
      if (m_pre == CLK_DIV) begin
        m_pre = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_st = M_DONE; m_done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    #2;
    chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    #10 rst_n = 1'b1;

    // name, clr, ld, st, ps, sf, sm, n, exp fen, exp miao, run, done
    add("load0100", 0, 1, 0, 0, 8'h01, 8'h00, 1, 8'h01, 8'h00, 0, 0);
    add("start",    0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h01, 8'h00, 1, 0);
    add("pre1to3",  0, 0, 0, 0, 8'h00, 8'h00, 3, 8'h01, 8'h00, 1, 0);
    add("borrow59", 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h59, 1, 0);
    add("hold59",   0, 0, 0, 0, 8'h00, 8'h00, 3, 8'h00, 8'h59, 1, 0);
    add("tick58",   0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h58, 1, 0);
    add("clear1",   1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    add("load0003", 0, 1, 0, 0, 8'h00, 8'h03, 1, 8'h00, 8'h03, 0, 0);
    add("start3",   0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h00, 8'h03, 1, 0);
    add("hold03",   0, 0, 0, 0, 8'h00, 8'h00, 3, 8'h00, 8'h03, 1, 0);
    add("tick02",   0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h02, 1, 0);
    add("hold02",   0, 0, 0, 0, 8'h00, 8'h00, 3, 8'h00, 8'h02, 1, 0);
    add("tick01",   0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h01, 1, 0);
    add("hold01",   0, 0, 0, 0, 8'h00, 8'h00, 3, 8'h00, 8'h01, 1, 0);
    add("tick00",   0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 1);
    add("donehold", 0, 0, 1, 0, 8'h00, 8'h00, 6, 8'h00, 8'h00, 0, 0);
    add("load1000", 0, 1, 0, 0, 8'h10, 8'h00, 1, 8'h10, 8'h00, 0, 0);
    add("start10",  0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h10, 8'h00, 1, 0);
    add("hold10",   0, 0, 0, 0, 8'h00, 8'h00, 3, 8'h10, 8'h00, 1, 0);
    add("bcd0959",  0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h09, 8'h59, 1, 0);
    add("clear2",   1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    add("clamp",    0, 1, 0, 0, 8'hAB, 8'h7C, 1, 8'h99, 8'h59, 0, 0);
    add("startP",   0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h99, 8'h59, 1, 0);
    add("preP",     0, 0, 0, 0, 8'h00, 8'h00, 2, 8'h99, 8'h59, 1, 0);
    add("pause",    0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h99, 8'h59, 0, 0);
    add("frozen",   0, 0, 0, 0, 8'h00, 8'h00, 20, 8'h99, 8'h59, 0, 0);
    add("resume",   0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h99, 8'h59, 1, 0);
    add("resume+1", 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h99, 8'h59, 1, 0);
    add("resume+2", 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h99, 8'h58, 1, 0);
    add("clr+start",1, 0, 1, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    add("nodone",   0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    add("start0000",0, 0, 1, 0, 8'h00, 8'h00, 2, 8'h00, 8'h00, 0, 0);
    add("load0005", 0, 1, 0, 0, 8'h00, 8'h05, 1, 8'h00, 8'h05, 0, 0);
    add("start5",   0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h00, 8'h05, 1, 0);
    add("ldInRun",  0, 1, 0, 0, 8'h12, 8'h34, 1, 8'h00, 8'h05, 1, 0);
    add("pause5",   0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h05, 0, 0);
    add("ld+start", 0, 1, 1, 0, 8'h00, 8'h07, 1, 8'h00, 8'h07, 0, 0);
    add("idle07",   0, 0, 0, 0, 8'h00, 8'h00, 6, 8'h00, 8'h07, 0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].clr, tbl[i].ld, tbl[i].st, tbl[i].ps, tbl[i].sf, tbl[i].sm);
        @(posedge clk); #1;
        chk_all(tbl[i].nm, tbl[i].ef, tbl[i].em, tbl[i].er, tbl[i].ed);
      end
    end

    // Asynchronous reset in the middle of a running count.
    drive(0, 1, 0, 0, 8'h02, 8'h30);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 8'h00, 8'h00);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk_all("prereset", 8'h02, 8'h29, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("asyncrst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("inreset", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Randomized commands against the reference model.
    m_st = M_IDLE; m_secs = 0; m_pre = 0; m_done = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      clear    = ($urandom % 60) == 0;
      load     = ($urandom % 20) == 0;
      start    = ($urandom % 4) == 0;
      pause    = ($urandom % 15) == 0;
      set_fen  = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
      set_miao = (($urandom % 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      @(posedge clk);
      model_step();
      #1;
      chk_all("random", to_bcd(m_secs / 60), to_bcd(m_secs % 60), m_st == M_RUN, m_done);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
